// File: rtl/disp_scan_sched_pkg.sv
// Shared constants and types for the 3-digit display scan scheduler.
package disp_scan_sched_pkg;

  localparam logic [1:0] SLOT_UNITS    = 2'd0;
  localparam logic [1:0] SLOT_TENS     = 2'd1;
  localparam logic [1:0] SLOT_HUNDREDS = 2'd2;

  localparam logic [3:0] ITER_MAX = 4'd8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } conv_state_t;

endpackage

// File: rtl/disp_scan_sched_bin2bcd.sv
// Iterative double-dabble converter: 8-bit binary to 3 BCD digits, one bit per cycle.
module bin2bcd_iter
  import disp_scan_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        done,
  output logic [3:0]  hund,
  output logic [3:0]  tens,
  output logic [3:0]  units,
  output conv_state_t state_dbg
);

  conv_state_t state_q, state_d;
  logic [19:0] sh_q;
  logic [19:0] adj;
  logic [3:0]  cnt_q;

  // Add-3 correction on each BCD nibble before the shift.
  always_comb begin
    adj = sh_q;
    if (sh_q[11:8]  >= 4'd5) adj[11:8]  = sh_q[11:8]  + 4'd3;
    if (sh_q[15:12] >= 4'd5) adj[15:12] = sh_q[15:12] + 4'd3;
    if (sh_q[19:16] >= 4'd5) adj[19:16] = sh_q[19:16] + 4'd3;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == ITER_MAX) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        sh_q  <= {12'b0, bin};
        cnt_q <= '0;
      end else if (state_q == SHIFT && cnt_q != ITER_MAX) begin
        sh_q  <= {adj[18:0], 1'b0};
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

  // done is high on the cycle whose edge commits the finished digits.
  assign done      = (state_q == SHIFT) && (cnt_q == ITER_MAX);
  assign hund      = sh_q[19:16];
  assign tens      = sh_q[15:12];
  assign units     = sh_q[11:8];
  assign state_dbg = state_q;

endmodule

// File: rtl/disp_scan_sched.sv
// 3-digit multiplexed 7-segment scheduler: binary intake, BCD buffer, scan, blanking, dimming.
module disp_scan_sched
  import disp_scan_sched_pkg::*;
#(
  parameter int SCAN_LOG2      = 14,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] val_in,
  input  logic       val_valid,
  output logic       val_ready,
  input  logic [1:0] bright,
  input  logic       lz_en,
  output logic [2:0] dig_sel_n,
  output logic [3:0] bcd_out,
  output logic       busy
);

  localparam logic [2:0] ALL_OFF = (DIG_ACTIVE_LOW != 0) ? 3'b111 : 3'b000;

  conv_state_t conv_state;
  logic        conv_done;
  logic [3:0]  conv_h, conv_t, conv_u;
  logic [3:0]  buf_h, buf_t, buf_u;
  logic        accept;

  // Handshake: a value transfers on any clk edge where val_valid && val_ready;
  // val_ready is high only while the converter is idle, nothing is queued.
  assign val_ready = (conv_state == IDLE);
  assign busy      = (conv_state == SHIFT);
  assign accept    = val_valid && val_ready;

  bin2bcd_iter u_conv (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (accept),
    .bin       (val_in),
    .done      (conv_done),
    .hund      (conv_h),
    .tens      (conv_t),
    .units     (conv_u),
    .state_dbg (conv_state)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_h <= '0;
      buf_t <= '0;
      buf_u <= '0;
    end else if (conv_done) begin
      buf_h <= conv_h;
      buf_t <= conv_t;
      buf_u <= conv_u;
    end
  end

  logic [SCAN_LOG2-1:0] phase_q;
  logic [1:0]           slot_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= '0;
      slot_q  <= SLOT_UNITS;
    end else begin
      phase_q <= phase_q + 1'b1;
      if (&phase_q)
        slot_q <= (slot_q == SLOT_HUNDREDS) ? SLOT_UNITS : slot_q + 2'd1;
    end
  end

  logic [3:0] digit;
  logic       blank, dim, lit;
  logic [2:0] en;
  logic [2:0] sel_d;
  logic [3:0] bcd_d;

  always_comb begin
    digit = buf_u;
    blank = 1'b0;
    case (slot_q)
      SLOT_TENS: begin
        digit = buf_t;
        blank = lz_en && (buf_h == 4'd0) && (buf_t == 4'd0);
      end
      SLOT_HUNDREDS: begin
        digit = buf_h;
        blank = lz_en && (buf_h == 4'd0);
      end
      default: begin
        digit = buf_u;
        blank = 1'b0;
      end
    endcase
    // Top two phase bits form a quarter-slot index compared against brightness.
    dim   = phase_q[SCAN_LOG2-1 -: 2] > bright;
    lit   = !blank && !dim;
    en    = 3'b001 << slot_q;
    sel_d = ALL_OFF;
    bcd_d = 4'd0;
    if (lit) begin
      sel_d = (DIG_ACTIVE_LOW != 0) ? ~en : en;
      bcd_d = digit;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dig_sel_n <= ALL_OFF;
      bcd_out   <= 4'd0;
    end else begin
      dig_sel_n <= sel_d;
      bcd_out   <= bcd_d;
    end
  end

endmodule
